mem_wb: RTL and testbench
=========================

MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 Parameter DM_MAX_WAIT, default 15, maximum dm_ready wait cycles before a bus error.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 valid  in  1  EX-stage result present; alu_out  in  32  registered ALU result / memory address; rs2_data  in  32  store data.
REQ-005 mem_rd, mem_wr  in  1 each  load/store; funct3  in  3  access size/sign; rd_addr  in  5; reg_wr  in  1.
REQ-006 dm_req  out  1; dm_we  out  1; dm_addr  out  32; dm_wstrb  out  4; dm_wdata  out  32; dm_rdata  in  32; dm_ready  in  1.
REQ-007 stall  out  1  upstream hold; bus_err  out  1  one-cycle error pulse; misaligned  out  1  one-cycle pulse.
REQ-008 wb_valid, wb_reg_wr  out  1 each; wb_rd_addr  out  5; wb_data  out  32  registered writeback.
REQ-009 fwd_valid  out  1; fwd_rd_addr  out  5; fwd_data  out  32  forwarding source for EX (rd_from_MEM).

Function
REQ-010 FSM states IDLE and WAIT; counter wait_cnt, width clog2(DM_MAX_WAIT+1).
REQ-011 IDLE, valid & (mem_rd|mem_wr): dm_req=1 same cycle (combinational); dm_ready same cycle -> complete, stay IDLE, stall=0.
REQ-012 IDLE, memory op, dm_ready=0 -> WAIT, stall=1; upstream holds all inputs stable while stall=1.
REQ-013 WAIT: dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata held constant; wait_cnt increments per cycle.
REQ-014 WAIT, dm_ready=1 -> complete, IDLE, wait_cnt=0, stall deasserts that cycle.
REQ-015 WAIT, wait_cnt==DM_MAX_WAIT & dm_ready=0 -> dm_req dropped next cycle, bus_err pulse, wb_valid=1 with wb_reg_wr=0, IDLE.
REQ-016 dm_ready ignored when dm_req=0; stall = memory op & ~completion this cycle.
REQ-017 Non-memory valid op: 1-cycle pass-through, wb_data=alu_out, no dm_req.
REQ-018 Store: funct3 000/001/010 -> wstrb 0001<<a, 0011<<a, 1111 (a=alu_out[1:0]); wdata byte/half replicated across lanes.
REQ-019 Load: lane selected by a; 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU, 101 LHU zero-ext; others treated as LW.
REQ-020 On completion/pass-through: wb_valid=1, wb_rd_addr=rd_addr, wb_reg_wr=reg_wr & (rd_addr!=0) & ~mem_wr; else wb_valid=0.
REQ-021 fwd_valid=wb_valid & wb_reg_wr; fwd_rd_addr=wb_rd_addr; fwd_data=wb_data (no extra latency).
REQ-022 dm_addr = {alu_out[31:2],2'b00}; dm_we=mem_wr.

Reset
REQ-023 rst asserted: dm_req=0 immediately, state IDLE, wait_cnt=0, all wb_*/fwd_*/bus_err/misaligned=0, stall=0.
REQ-024 rst mid-WAIT aborts access; no writeback, no bus_err issued.

Configuration
REQ-025 MEM_MISALIGN_CHK_EN defined: half op with a[0]=1 or word op with a!=0 -> no dm_req, misaligned pulse next cycle, wb_valid=1, wb_reg_wr=0.
REQ-026 MEM_MISALIGN_CHK_EN undefined: misaligned tied 0; half ops use a[1] only, word ops ignore a.

Structure
REQ-027 Package mem_pkg holds funct3 localparams (LB..LHU, SB..SW) and state enum typedef.
REQ-028 Sub-module load_align: combinational lane select plus sign/zero extension.

Verification
REQ-029 SW alu_out=0x100, rs2=0xDEADBEEF, dm_ready=1 same cycle -> dm_wstrb=1111, stall=0, wb_reg_wr=0.
REQ-030 LB rd=5, a=3, dm_rdata=0x80FF_FFFF, dm_ready after 3 cycles -> stall 3 cycles, wb_data=0xFFFFFF80.
REQ-031 LHU a=2, dm_rdata=0xBEEF0000 -> wb_data=0x0000BEEF; fwd_valid=1, fwd_rd_addr=rd.
REQ-032 Load, dm_ready never -> after DM_MAX_WAIT+1 cycles bus_err pulse, stall releases, wb_reg_wr=0.
REQ-033 rst during WAIT -> dm_req=0 same cycle, all outputs 0; LW a=1 with macro -> misaligned=1, no dm_req.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM/WB stage: funct3 encodings for loads and
// stores, the access-state enumeration, and store-lane helper functions.
//
// Access size is decoded from funct3[1:0]: 00 byte, 01 half, anything else
// is handled as a full word (this is what makes the undefined load encodings
// behave as LW).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Byte-enable pattern for a store; half-words pick their lane from a[1].
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] strb;
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << a;
            2'b01:   strb = a[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Store data replicated across every lane so the strobes alone select it.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{d[7:0]}};
            2'b01:   wd = {2{d[15:0]}};
            default: wd = d;
        endcase
        return wd;
    endfunction

    // True when the address is not naturally aligned for the access size.
    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-data alignment: selects the addressed byte/half lane of
// the returned bus word and sign- or zero-extends it according to funct3.
//
// Ports
//   i_rdata   32  raw data-memory read word
//   i_lane     2  byte offset within the word (alu_out[1:0])
//   i_funct3   3  load type (LB/LH/LW/LBU/LHU, others behave as LW)
//   o_data    32  aligned, extended writeback value
// -----------------------------------------------------------------------------
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extraction followed by extension.
    always_comb begin
        w_byte = i_rdata[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'h000000, w_byte};
            F3_LHU:  o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// -----------------------------------------------------------------------------
// mem_wb
// MEM stage plus registered writeback. Issues data-memory requests for loads
// and stores, stalls upstream while the bus is busy, times out after
// DM_MAX_WAIT wait cycles with a bus-error pulse, and presents the registered
// writeback result (also used as the EX forwarding source).
//
// Optional feature: define MEM_MISALIGN_CHK_EN to reject misaligned half/word
// accesses (no bus request, misaligned pulse, writeback without reg write).
// Without it, misaligned is tied low and the low address bits are ignored
// where the access size does not need them.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   valid/alu_out/rs2_data   EX result, address, store data
//   mem_rd/mem_wr/funct3     access kind and size/sign
//   rd_addr/reg_wr           destination register
//   dm_*                     data-memory request/response bus
//   stall                    upstream hold (inputs stable while high)
//   bus_err/misaligned       one-cycle error pulses
//   wb_*                     registered writeback
//   fwd_*                    forwarding view of the writeback registers
// -----------------------------------------------------------------------------
module mem_wb
    import mem_pkg::*;
#(
    parameter int DM_MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_addr,
    input  logic        reg_wr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic        stall,
    output logic        bus_err,
    output logic        misaligned,
    output logic        wb_valid,
    output logic        wb_reg_wr,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd_addr,
    output logic [31:0] fwd_data
);

    localparam int CNT_W = (DM_MAX_WAIT > 0) ? $clog2(DM_MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DM_MAX_WAIT);

    mem_state_e       r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_wb_valid;
    logic             r_wb_reg_wr;
    logic [4:0]       r_wb_rd_addr;
    logic [31:0]      r_wb_data;
    logic             r_bus_err;
    logic             r_misaligned;

    mem_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_mem_op;
    logic             w_misal;
    logic             w_in_wait;
    logic             w_req;
    logic             w_done;
    logic             w_timeout;
    logic             w_pass;
    logic             w_good;
    logic             w_fire;
    logic             w_stall;
    logic             w_is_load;
    logic [31:0]      w_load_data;

    load_align u_load_align (
        .i_rdata  (dm_rdata),
        .i_lane   (alu_out[1:0]),
        .i_funct3 (funct3),
        .o_data   (w_load_data)
    );

    // Request/completion decode for the current cycle.
    always_comb begin
        w_mem_op  = valid & (mem_rd | mem_wr);
        w_in_wait = (r_state == ST_WAIT);
`ifdef MEM_MISALIGN_CHK_EN
        w_misal   = w_mem_op & ~w_in_wait & access_misaligned(funct3, alu_out[1:0]);
`else
        w_misal   = 1'b0;
`endif
        // Reset must drop the request immediately, not at the next edge.
        w_req     = ~rst & (w_in_wait | (w_mem_op & ~w_misal));
        w_done    = w_req & dm_ready;
        // The last permitted wait cycle ends the access without a response;
        // upstream is released here and the error is reported next cycle.
        w_timeout = w_req & w_in_wait & ~dm_ready & (r_wait_cnt == MAX_CNT);
        w_pass    = valid & ~w_mem_op & ~w_in_wait;
        w_good    = w_pass | w_done;
        w_fire    = w_good | w_timeout | w_misal;
        w_stall   = w_req & ~dm_ready & ~w_timeout;
        w_is_load = mem_rd & ~mem_wr;
    end

    // Access state and wait counter next-state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req & ~dm_ready) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            ST_WAIT: begin
                if (dm_ready | w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = r_wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered writeback / error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= {CNT_W{1'b0}};
            r_wb_valid   <= 1'b0;
            r_wb_reg_wr  <= 1'b0;
            r_wb_rd_addr <= 5'd0;
            r_wb_data    <= 32'h0000_0000;
            r_bus_err    <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_cnt_nxt;
            r_wb_valid   <= w_fire;
            // Faulted accesses still retire but never write the register file.
            r_wb_reg_wr  <= w_good & reg_wr & (rd_addr != 5'd0) & ~mem_wr;
            r_wb_rd_addr <= w_fire ? rd_addr : 5'd0;
            r_wb_data    <= (w_done & w_is_load) ? w_load_data :
                            (w_fire ? alu_out : 32'h0000_0000);
            r_bus_err    <= w_timeout;
            r_misaligned <= w_misal;
        end
    end

    assign dm_req      = w_req;
    assign dm_we       = w_req & mem_wr;
    assign dm_addr     = w_req ? {alu_out[31:2], 2'b00} : 32'h0000_0000;
    assign dm_wstrb    = (w_req & mem_wr) ? store_strb(funct3, alu_out[1:0]) : 4'b0000;
    assign dm_wdata    = (w_req & mem_wr) ? store_data(funct3, rs2_data) : 32'h0000_0000;
    assign stall       = w_stall;

    assign bus_err     = r_bus_err;
    assign misaligned  = r_misaligned;
    assign wb_valid    = r_wb_valid;
    assign wb_reg_wr   = r_wb_reg_wr;
    assign wb_rd_addr  = r_wb_rd_addr;
    assign wb_data     = r_wb_data;
    assign fwd_valid   = r_wb_valid & r_wb_reg_wr;
    assign fwd_rd_addr = r_wb_rd_addr;
    assign fwd_data    = r_wb_data;

endmodule

// File: tb/tb_mem_wb.sv
// -----------------------------------------------------------------------------
// tb_mem_wb
// Self-checking bench for mem_wb. Each transaction's outcome (cycle count,
// stall pattern, bus strobes, writeback value) is worked out up front from the
// access rules; a compare process checks the DUT against those expectations
// on every falling edge. Directed cases with literal values pin the model.
// -----------------------------------------------------------------------------
module tb_mem_wb;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid, mem_rd, mem_wr, reg_wr, dm_ready;
    logic [31:0] alu_out, rs2_data, dm_rdata;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic        dm_req, dm_we, stall, bus_err, misaligned;
    logic        wb_valid, wb_reg_wr, fwd_valid;
    logic [31:0] dm_addr, dm_wdata, wb_data, fwd_data;
    logic [3:0]  dm_wstrb;
    logic [4:0]  wb_rd_addr, fwd_rd_addr;

    int n_chk  = 0;
    int n_fail = 0;

    // expectations: combinational (this cycle) and registered (visible now)
    logic        chk_en = 1'b0;
    logic        e_req, e_stall, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;
    logic        e_wb_valid, e_wb_reg_wr, e_bus_err, e_mis;
    logic [4:0]  e_wb_rd;
    logic [31:0] e_wb_data;

    // observations recorded by the driver for literal checks
    int          stall_seen;
    logic        first_req;
    logic [3:0]  first_strb;

    always #5 clk = ~clk;

    mem_wb #(.DM_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .valid(valid), .alu_out(alu_out), .rs2_data(rs2_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3), .rd_addr(rd_addr), .reg_wr(reg_wr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall(stall), .bus_err(bus_err), .misaligned(misaligned),
        .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (access rules as arithmetic) ----------
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        else if (f3 == 3'b001 || f3 == 3'b101) return 2;
        else return 4;
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_MISALIGN_CHK_EN
        return (addr % size_of(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned b, h;
        b = (rdata >> (8 * addr[1:0])) & 32'hFF;
        h = (rdata >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128)   ? b - 32'd256   : b;
            3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned s;
        if (size_of(f3) == 1) s = 1 << addr[1:0];
        else if (size_of(f3) == 2) s = 3 << (2 * addr[1]);
        else s = 15;
        return 4'(s);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (size_of(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
        else if (size_of(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        else return d;
    endfunction

    // ---------------- compare process ---------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("dm_req", {31'd0, dm_req}, {31'd0, e_req});
            check("stall", {31'd0, stall}, {31'd0, e_stall});
            if (e_req) begin
                check("dm_we", {31'd0, dm_we}, {31'd0, e_we});
                check("dm_addr", dm_addr, e_addr);
                if (e_we) begin
                    check("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, e_strb});
                    check("dm_wdata", dm_wdata, e_wdata);
                end
            end
            check("wb_valid", {31'd0, wb_valid}, {31'd0, e_wb_valid});
            check("wb_reg_wr", {31'd0, wb_reg_wr}, {31'd0, e_wb_reg_wr});
            check("bus_err", {31'd0, bus_err}, {31'd0, e_bus_err});
            check("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
            check("fwd_valid", {31'd0, fwd_valid}, {31'd0, e_wb_valid & e_wb_reg_wr});
            if (e_wb_valid) check("wb_rd_addr", {27'd0, wb_rd_addr}, {27'd0, e_wb_rd});
            if (e_wb_valid && e_wb_reg_wr) begin
                check("wb_data", wb_data, e_wb_data);
                check("fwd_rd_addr", {27'd0, fwd_rd_addr}, {27'd0, e_wb_rd});
                check("fwd_data", fwd_data, e_wb_data);
            end
        end
    end

    // ---------------- driver helpers ----------------------------------------
    task automatic clear_reg();
        e_wb_valid = 1'b0; e_wb_reg_wr = 1'b0; e_bus_err = 1'b0; e_mis = 1'b0;
        e_wb_rd = 5'd0; e_wb_data = 32'd0;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        dm_ready = 1'($urandom_range(0, 1));
        dm_rdata = $urandom();
        e_req = 1'b0; e_stall = 1'b0; e_we = 1'b0;
        e_addr = 32'd0; e_strb = 4'd0; e_wdata = 32'd0;
    endtask

    // One idle cycle: the result of an idle cycle is an empty writeback.
    task automatic settle();
        @(posedge clk); #1;
        clear_reg();
        idle_inputs();
    endtask

    // Drive one EX result; called at posedge+1, returns at posedge+1 after
    // the final cycle with idle inputs applied.
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] ldata, input logic [4:0] rd,
                           input logic rw, input int lat);
        logic        mem, mis, ok;
        int          ncyc;
        logic [31:0] res;
        mem  = ld | st;
        mis  = mem & ref_misaligned(f3, addr);
        if (!mem || mis) ncyc = 1;
        else if (lat <= MAXW + 1) ncyc = lat + 1;
        else ncyc = MAXW + 2;
        ok   = !mem || (!mis && lat <= MAXW + 1);
        res  = (mem && ok && ld) ? ref_load(f3, addr, ldata) : addr;

        valid = 1'b1; mem_rd = ld; mem_wr = st; funct3 = f3; alu_out = addr;
        rs2_data = sdata; rd_addr = rd; reg_wr = rw;
        e_req   = mem & ~mis;
        e_we    = st;
        e_addr  = addr & 32'hFFFF_FFFC;
        e_strb  = ref_strb(f3, addr);
        e_wdata = ref_wdata(f3, sdata);
        stall_seen = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (e_req) dm_ready = (c >= lat);
            else dm_ready = 1'($urandom_range(0, 1));
            dm_rdata = (e_req && c >= lat) ? ldata : $urandom();
            e_stall  = (c != ncyc - 1);
            @(negedge clk);
            if (stall) stall_seen++;
            if (c == 0) begin
                first_req  = dm_req;
                first_strb = dm_wstrb;
            end
            @(posedge clk); #1;
            if (c == ncyc - 1) begin
                e_wb_valid  = 1'b1;
                e_wb_reg_wr = ok & rw & (rd != 5'd0) & ~st;
                e_wb_rd     = rd;
                e_wb_data   = res;
                e_bus_err   = mem & ~mis & ~ok;
                e_mis       = mis;
            end else begin
                clear_reg();
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence -----------------------------------------
    initial begin
        logic        r_ld, r_st, r_rw;
        logic [2:0]  r_f3;
        logic [31:0] r_addr, r_sd, r_ldat;
        logic [4:0]  r_rd;
        int          r_lat, r_kind, r_pick;

        // Reset held with a load presented: nothing may reach the bus.
        valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; alu_out = 32'h100;
        rs2_data = 32'd0; rd_addr = 5'd1; reg_wr = 1'b1; dm_rdata = 32'd0; dm_ready = 1'b1;
        e_req = 1'b0; e_stall = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_strb = 4'd0; e_wdata = 32'd0;
        clear_reg();
        @(negedge clk);
        check("rst_dm_req", {31'd0, dm_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        chk_en = 1'b1;
        settle();

        // SW 0x100 <- 0xDEADBEEF, ready in the first cycle.
        run_txn(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 5'd3, 1'b1, 0);
        @(negedge clk);
        check("lit_sw_strb", {28'd0, first_strb}, 32'h0000_000F);
        check("lit_sw_stall", stall_seen, 32'd0);
        check("lit_sw_regwr", {31'd0, wb_reg_wr}, 32'd0);
        settle();

        // LB rd=5 at offset 3, ready after 3 wait cycles.
        run_txn(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'd0, 32'h80FF_FFFF, 5'd5, 1'b1, 3);
        @(negedge clk);
        check("lit_lb_stall", stall_seen, 32'd3);
        check("lit_lb_data", wb_data, 32'hFFFF_FF80);
        settle();

        // LHU at offset 2 feeds forwarding.
        run_txn(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'd0, 32'hBEEF_0000, 5'd7, 1'b1, 1);
        @(negedge clk);
        check("lit_lhu_data", wb_data, 32'h0000_BEEF);
        check("lit_lhu_fwd", {31'd0, fwd_valid}, 32'd1);
        check("lit_lhu_fwd_rd", {27'd0, fwd_rd_addr}, 32'd7);
        settle();

        // Ready on the very last permitted wait cycle: normal completion.
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h1234_5678, 5'd8, 1'b1, MAXW + 1);
        @(negedge clk);
        check("lit_edge_stall", stall_seen, MAXW + 1);
        check("lit_edge_buserr", {31'd0, bus_err}, 32'd0);
        check("lit_edge_data", wb_data, 32'h1234_5678);
        settle();

        // No response at all: bus error after the wait budget.
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'd0, 5'd9, 1'b1, 1000);
        @(negedge clk);
        check("lit_to_stall", stall_seen, MAXW + 1);
        check("lit_to_buserr", {31'd0, bus_err}, 32'd1);
        check("lit_to_wbvalid", {31'd0, wb_valid}, 32'd1);
        check("lit_to_regwr", {31'd0, wb_reg_wr}, 32'd0);
        settle();

        // LW at offset 1.
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0601, 32'd0, 32'hCAFE_F00D, 5'd10, 1'b1, 0);
        @(negedge clk);
`ifdef MEM_MISALIGN_CHK_EN
        check("lit_mis_req", {31'd0, first_req}, 32'd0);
        check("lit_mis_pulse", {31'd0, misaligned}, 32'd1);
`else
        check("lit_mis_req", {31'd0, first_req}, 32'd1);
        check("lit_mis_pulse", {31'd0, misaligned}, 32'd0);
`endif
        settle();

        // Randomized traffic, with occasional idle gaps between results.
        for (int t = 0; t < 300; t++) begin
            r_kind = $urandom_range(0, 9);
            r_ld   = (r_kind >= 3 && r_kind < 6);
            r_st   = (r_kind >= 6);
            r_f3   = r_st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            r_addr = $urandom();
            r_sd   = $urandom();
            r_ldat = $urandom();
            r_rd   = 5'($urandom_range(0, 31));
            r_rw   = ($urandom_range(0, 3) != 0);
            r_pick = $urandom_range(0, 19);
            if (r_pick < 8) r_lat = 0;
            else if (r_pick < 18) r_lat = $urandom_range(1, MAXW + 1);
            else r_lat = MAXW + 2 + $urandom_range(0, 3);
            run_txn(r_ld, r_st, r_f3, r_addr, r_sd, r_ldat, r_rd, r_rw, r_lat);
            if ($urandom_range(0, 3) == 0) settle();
        end
        settle();

        // Reset in the middle of a wait: request drops at once, nothing retires.
        chk_en = 1'b0;
        valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; alu_out = 32'h0000_0700;
        rd_addr = 5'd11; reg_wr = 1'b1; dm_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("wait_req", {31'd0, dm_req}, 32'd1);
        check("wait_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_wait_req", {31'd0, dm_req}, 32'd0);
        check("rst_wait_stall", {31'd0, stall}, 32'd0);
        check("rst_wait_addr", dm_addr, 32'd0);
        check("rst_wait_wbvalid", {31'd0, wb_valid}, 32'd0);
        check("rst_wait_buserr", {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        clear_reg();
        chk_en = 1'b1;
        for (int k = 0; k < MAXW + 4; k++) settle();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
